io_controller: RTL and testbench

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_controller_if.sv | 25 ++
 rtl/io_controller.sv | 129 ++++++++++++
 tb/tb_io_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_controller_if.sv
// Processor/board-facing signals of io_controller, grouped into one bundle.
// The controller takes the slave modport; the processor/board side takes master.
interface io_controller_if;
    logic        op_in;
    logic        op_out;
    logic [5:0]  funct;
    logic [15:0] switches;
    logic        confirm_btn;
    logic [31:0] data;
    logic        halt;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] display;
    logic        waiting;

    modport master (
        output op_in, op_out, funct, switches, confirm_btn, data,
        input  halt, in_data, in_valid, display, waiting
    );

    modport slave (
        input  op_in, op_out, funct, switches, confirm_btn, data,
        output halt, in_data, in_valid, display, waiting
    );
endinterface

// File: rtl/io_controller.sv
// Switch/button input and display output controller with a processor stall handshake.
// Define IO_DEBOUNCE_EN to debounce confirm_btn over DEBOUNCE_CYCLES stable cycles.
module io_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic           clock,
    input  logic           reset,
    io_controller_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWaitPress, StWaitRelease, StDone} state_e;

    state_e      state_q;
    logic        sync1_q, sync2_q;
    logic        btn_db, btn_db_prev_q;
    logic [31:0] in_data_q, display_q;
    logic        in_valid_q, waiting_q;
    logic [31:0] sel_value;

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be non-zero");
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.confirm_btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;

    // Any cycle where the synchronized level agrees with btn_db restarts the count.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    assign btn_db = btn_db_q;
`else
    assign btn_db = sync2_q;
`endif

    always_comb begin
        sel_value = '0;
        if (bus.funct < 6'd16) begin
            sel_value = {31'b0, bus.switches[bus.funct[3:0]]};
        end else if (bus.funct == 6'd22) begin
            sel_value = {24'b0, bus.switches[7:0]};
        end else if (bus.funct == 6'd23) begin
            sel_value = {16'b0, bus.switches};
        end
    end

    // btn_db_prev_q tracks continuously so a level already high on entry never looks like an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            btn_db_prev_q <= 1'b0;
            in_data_q     <= '0;
            display_q     <= '0;
            in_valid_q    <= 1'b0;
            waiting_q     <= 1'b0;
        end else begin
            btn_db_prev_q <= btn_db;
            in_valid_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.op_in) begin
                        state_q   <= StWaitPress;
                        waiting_q <= 1'b1;
                    end else if (bus.op_out) begin
                        display_q <= bus.data;
                    end
                end
                StWaitPress: begin
                    if (btn_db && !btn_db_prev_q) begin
                        in_data_q <= sel_value;
                        state_q   <= StWaitRelease;
                        waiting_q <= 1'b0;
                    end
                end
                StWaitRelease: begin
                    if (!btn_db) begin
                        state_q    <= StDone;
                        in_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q   <= StIdle;
                    waiting_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.halt     = !reset && ((state_q == StIdle && bus.op_in) ||
                                     state_q == StWaitPress || state_q == StWaitRelease);
    assign bus.in_data  = in_data_q;
    assign bus.in_valid = in_valid_q;
    assign bus.display  = display_q;
    assign bus.waiting  = waiting_q;
endmodule

// File: tb/tb_io_controller.sv
// Randomized self-checking bench for io_controller against a run-length button model.
// Works with IO_DEBOUNCE_EN defined or undefined.
module tb_io_controller;
    localparam int unsigned DebCycles = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int EffN = DebCycles;
`else
    localparam int EffN = 1;
`endif

    logic clock = 1'b0;
    logic reset;

    io_controller_if bus ();

    io_controller #(.DEBOUNCE_CYCLES(DebCycles)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    int          pulse_cnt;
    int          halt_err;
    bit          in_txn;
    logic        halt_at_valid;
    logic [31:0] display_m;
    logic [31:0] in_data_m;
    bit          pat[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] select_ref(input logic [5:0] f, input logic [15:0] sw);
        logic [31:0] w;
        w = {16'h0, sw};
        if (f < 6'd16) return (w >> f) & 32'h1;
        if (f == 6'd22) return w & 32'hFF;
        if (f == 6'd23) return w;
        return 32'h0;
    endfunction

    // Accepted level flips after EffN consecutive opposite samples; count accepted rises.
    function automatic int rises_ref(input bit start_lvl);
        bit lvl;
        int run;
        int n;
        lvl = start_lvl;
        run = 0;
        n   = 0;
        foreach (pat[i]) begin
            if (pat[i] != lvl) run++;
            else run = 0;
            if (run >= EffN) begin
                lvl = pat[i];
                run = 0;
                if (lvl) n++;
            end
        end
        return n;
    endfunction

    // Processor model: on in_valid it releases op_in/op_out immediately.
    task automatic step();
        @(negedge clock);
        if (bus.in_valid === 1'b1) begin
            pulse_cnt++;
            halt_at_valid = bus.halt;
            in_txn        = 1'b0;
            bus.op_in     = 1'b0;
            bus.op_out    = 1'b0;
        end else if (in_txn && bus.halt !== 1'b1) begin
            halt_err++;
        end
    endtask

    task automatic run_read(input logic [5:0] f, input logic [15:0] sw, input bit start_lvl,
                            input bit with_out, input string tag);
        int exp_pulses;
        exp_pulses    = (rises_ref(start_lvl) > 0) ? 1 : 0;
        pulse_cnt     = 0;
        halt_err      = 0;
        in_txn        = 1'b1;
        halt_at_valid = 1'bx;
        bus.op_in     = 1'b1;
        bus.funct     = f;
        bus.switches  = sw;
        if (with_out) begin
            bus.op_out = 1'b1;
            bus.data   = $urandom;
        end
        step();
        foreach (pat[i]) begin
            bus.confirm_btn = pat[i];
            step();
        end
        bus.confirm_btn = 1'b0;
        repeat (EffN + 6) step();
        bus.op_out = 1'b0;
        if (exp_pulses == 1) in_data_m = select_ref(f, sw);
        check_eq({tag, " pulses"}, 32'(pulse_cnt), 32'(exp_pulses));
        check_eq({tag, " halt_held"}, 32'(halt_err), 32'd0);
        check_eq({tag, " in_data"}, bus.in_data, in_data_m);
        check_eq({tag, " waiting"}, 32'(bus.waiting), (exp_pulses == 1) ? 32'd0 : 32'd1);
        check_eq({tag, " display"}, bus.display, display_m);
        if (exp_pulses == 1) check_eq({tag, " halt_done"}, 32'(halt_at_valid), 32'd0);
    endtask

    task automatic clean_pattern(input int hold);
        pat.delete();
        repeat (hold) pat.push_back(1'b1);
        repeat (EffN + 6) pat.push_back(1'b0);
    endtask

    initial begin
        logic [5:0]  f;
        logic [15:0] sw;
        logic [31:0] d;
        int          g;

        reset           = 1'b1;
        bus.op_in       = 1'b1;
        bus.op_out      = 1'b0;
        bus.funct       = '0;
        bus.switches    = '0;
        bus.confirm_btn = 1'b0;
        bus.data        = '0;
        in_txn          = 1'b0;
        pulse_cnt       = 0;
        halt_err        = 0;
        display_m       = '0;
        in_data_m       = '0;

        repeat (2) @(negedge clock);
        check_eq("reset halt", 32'(bus.halt), 32'd0);
        check_eq("reset in_valid", 32'(bus.in_valid), 32'd0);
        check_eq("reset in_data", bus.in_data, 32'd0);
        check_eq("reset display", bus.display, 32'd0);
        check_eq("reset waiting", 32'(bus.waiting), 32'd0);
        bus.op_in = 1'b0;
        reset     = 1'b0;
        repeat (2) step();

        // Output writes from IDLE.
        bus.data   = 32'h0000_1234;
        bus.op_out = 1'b1;
        step();
        display_m = 32'h0000_1234;
        check_eq("out 1234 display", bus.display, display_m);
        check_eq("out 1234 halt", 32'(bus.halt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            d          = $urandom;
            bus.data   = d;
            bus.op_out = 1'b1;
            step();
            display_m = d;
            check_eq("out rand display", bus.display, display_m);
        end
        bus.op_out = 1'b0;
        bus.data   = $urandom;
        step();
        check_eq("out hold display", bus.display, display_m);

        // Directed reads.
        clean_pattern(EffN + 2);
        run_read(6'd23, 16'hBEEF, 1'b0, 1'b1, "rd beef");
        run_read(6'd5, 16'h0020, 1'b0, 1'b0, "rd bit5");
        run_read(6'd22, 16'hA5C3, 1'b0, 1'b1, "rd low8");
        run_read(6'd30, 16'hFFFF, 1'b0, 1'b0, "rd other");

        // Bounce 1,0,1,0 then a clean hold.
        pat.delete();
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        repeat (EffN + 6) pat.push_back(1'b0);
        run_read(6'd23, 16'h5A5A, 1'b0, 1'b0, "rd bounce");

        // Glitches only, then a clean press to finish the read if still waiting.
        pat.delete();
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        repeat (EffN + 6) pat.push_back(1'b0);
        run_read(6'd23, 16'h1357, 1'b0, 1'b0, "rd glitch");
        clean_pattern(EffN + 1);
        run_read(6'd22, 16'h2468, 1'b0, 1'b0, "rd after glitch");

        // Button already held when op_in rises.
        bus.confirm_btn = 1'b1;
        repeat (3 * EffN + 6) step();
        pat.delete();
        repeat (3 * EffN + 2) pat.push_back(1'b1);
        repeat (3 * EffN + 2) pat.push_back(1'b0);
        repeat (EffN + 1) pat.push_back(1'b1);
        repeat (EffN + 6) pat.push_back(1'b0);
        run_read(6'd23, 16'hC0DE, 1'b1, 1'b0, "rd held");

        // Randomized reads.
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 3))
                0:       f = 6'($urandom_range(0, 15));
                1:       f = 6'd22;
                2:       f = 6'd23;
                default: f = 6'($urandom_range(16, 63));
            endcase
            sw = 16'($urandom);
            pat.delete();
            repeat ($urandom_range(0, 2)) pat.push_back(1'b0);
            g = $urandom_range(0, 3);
            repeat (g) begin
                pat.push_back(1'b1);
                pat.push_back(1'b0);
            end
            repeat (EffN + $urandom_range(0, 3)) pat.push_back(1'b1);
            repeat (EffN + 6) pat.push_back(1'b0);
            run_read(f, sw, 1'b0, 1'($urandom_range(0, 1)), "rd rand");
        end

        // Reset in the middle of a wait.
        bus.op_in    = 1'b1;
        bus.funct    = 6'd23;
        bus.switches = 16'h1234;
        in_txn       = 1'b0;
        pulse_cnt    = 0;
        repeat (3) step();
        check_eq("rst wait waiting", 32'(bus.waiting), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst wait halt", 32'(bus.halt), 32'd0);
        check_eq("rst wait in_valid", 32'(bus.in_valid), 32'd0);
        step();
        display_m = '0;
        in_data_m = '0;
        check_eq("rst wait display", bus.display, display_m);
        check_eq("rst wait in_data", bus.in_data, in_data_m);
        check_eq("rst wait waiting0", 32'(bus.waiting), 32'd0);
        bus.op_in = 1'b0;
        step();
        reset = 1'b0;
        repeat (3 * EffN + 6) step();
        check_eq("rst wait no pulse", 32'(pulse_cnt), 32'd0);
        check_eq("rst wait halt after", 32'(bus.halt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
